i2s_receiver: RTL and testbench
===============================

# i2s_receiver

Recovers 16-bit stereo samples from an external Philips I2S stream (bit clock, word select, serial data) and presents them as a coherent left/right pair in the `clk` domain. It is the receive counterpart of the synth's I2S transmit path: it feeds codec/ADC audio into the NCO/mixer chain and serves as a loopback checker for the transmitter. All three I2S inputs are asynchronous to `clk` and are synchronised internally.

## Interface
- `DATA_WIDTH`, 16: bits per channel slot and per output sample.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth on `bit_clock`, `word_select` and `sound_data`; minimum 2.
- `clk`  in  1  master clock, 24.576 MHz.
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high.
- `bit_clock`  in  1  I2S BCLK, asynchronous; high and low phases each at least 3 `clk` periods.
- `word_select`  in  1  I2S WS, asynchronous; 0 = left, 1 = right.
- `sound_data`  in  1  I2S SD, asynchronous, MSB first.
- `left_sample`  out  DATA_WIDTH  last complete left word, held between updates.
- `right_sample`  out  DATA_WIDTH  last complete right word, held between updates.
- `sample_valid`  out  1  one-`clk` pulse; `left_sample` and `right_sample` updated together this cycle.
- `frame_error`  out  1  one-`clk` pulse; a slot of the wrong length was discarded.
- `testing_bit_counter`  out  5  current `bit_cnt`, for debug.

## Operation
- Synchroniser and detection:
  - `bit_clock`, `word_select` and `sound_data` each pass through SYNC_STAGES flops.
  - `bclk_rise` = synchronised bclk high AND delayed copy low.
  - All logic below advances only on cycles with `bclk_rise`. WS and SD are taken from the synchronised values in that cycle.
- Registers:
  - `shift` (DATA_WIDTH): shifts left, SD enters at the LSB.
  - `ws_prev`: WS at the previous rise.
  - `bit_cnt` (5b): saturates at 31.
  - `left_hold`, `left_ok`.
- FSM `HUNT` (reset state):
  - Shift, and track `ws_prev`.
  - On the first rise where WS != `ws_prev`, discard the word, clear `bit_cnt`, and go to `RECEIVE`.
- FSM `RECEIVE`:
  - Rise with WS == `ws_prev`: shift, `bit_cnt`++.
  - Rise with WS != `ws_prev` (transition): the SD on this rise is the LSB of channel `ws_prev`, and `word` = {`shift`[DATA_WIDTH-2:0], SD}.
    - If `bit_cnt` == DATA_WIDTH-1, the word is good.
    - Otherwise pulse `frame_error` and treat the word as bad.
    - In both cases clear `bit_cnt` and keep shifting.
- Good left word: `left_hold` <= `word`, `left_ok` <= 1. Bad left word: `left_ok` <= 0.
- Good right word with `left_ok` = 1: `left_sample` <= `left_hold`, `right_sample` <= `word`, pulse `sample_valid`, `left_ok` <= 0.
- Bad right word, or `left_ok` = 0: no output update. Also clear `left_ok`.
- Only a left-then-right pair from the same frame is ever emitted. An orphan right word is dropped silently; no error is raised for it.
- The FSM never returns to `HUNT` except on reset.

## Timing
- Reset values: `left_sample` = 0, `right_sample` = 0, `sample_valid` = 0, `frame_error` = 0, `testing_bit_counter` = 0. Also `shift` = 0, `ws_prev` = 0, `left_ok` = 0, state `HUNT`.
- Reset asserted mid-frame: clears everything immediately, with no pulse. After release the receiver re-hunts, so the first pair is emitted no earlier than the second WS transition after release.
- Latency: `sample_valid` is high SYNC_STAGES+1 `clk` cycles after the first `clk` edge that samples the WS-transition BCLK rise high. For SYNC_STAGES = 2 that is 3 cycles.
- `sample_valid` and `frame_error` are each exactly 1 cycle wide. They never coincide, because an error always suppresses the pair.
- Transmitter at clk/8 BCLK with 16-bit slots: 32 BCLKs per frame, so one `sample_valid` every 256 `clk` cycles (96 kHz).
- Slot-length edge cases:
  - `bit_cnt` saturates at 31: an overlong slot is an error, and there is no counter wrap.
  - A short slot (e.g. 8 bits) is an error.
  - WS toggling on consecutive rises gives `bit_cnt` = 0 at the transition, which is an error.
- Outputs are registered. `left_sample`/`right_sample` are stable whenever `sample_valid` is low.

## Test plan
- Reset: hold `rst` = 1 with the I2S lines toggling -> all outputs 0, no pulses; deassert -> first `sample_valid` only after 2 WS transitions.
- Loopback from the transmitter: stream left 16'hA5C3 / right 16'h3C5A continuously -> each `sample_valid` shows exactly those values, with pulses 256 `clk` apart. `frame_error` never pulses after the first full frame.
- Latency: directed BCLK edge at the right-to-left WS transition -> `sample_valid` exactly 3 cycles after the synchroniser first samples BCLK high.
- Framing errors:
  - A 15-bit left slot -> one `frame_error` pulse, that frame produces no `sample_valid`, and outputs keep the previous pair.
  - A 20-bit right slot -> one `frame_error` pulse.
  - In both cases the next good frame is received normally.
- Boundary values: pairs 16'h0000/16'hFFFF, then 16'h8000/16'h0001 -> exact capture, confirming MSB-first order and the LSB landing on the transition edge.
- Reset mid-frame: assert `rst` after 7 bits of a left word -> outputs clear within the same cycle. After release the partial frame is discarded, and the next full pair is reported correctly.

Source files
------------

// File: rtl/i2s_receiver_if.sv
// I2S receive bus: serial inputs from the external link plus the
// recovered stereo pair and status pulses presented in the clk domain.
interface i2s_receiver_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  bit_clock;
  logic                  word_select;
  logic                  sound_data;
  logic [DATA_WIDTH-1:0] left_sample;
  logic [DATA_WIDTH-1:0] right_sample;
  logic                  sample_valid;
  logic                  frame_error;
  logic [4:0]            testing_bit_counter;

  // Source of the I2S stream and consumer of the recovered samples.
  modport master (
    output bit_clock, word_select, sound_data,
    input  left_sample, right_sample, sample_valid, frame_error,
           testing_bit_counter
  );

  // The receiver itself.
  modport slave (
    input  bit_clock, word_select, sound_data,
    output left_sample, right_sample, sample_valid, frame_error,
           testing_bit_counter
  );
endinterface

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: synchronises BCLK/WS/SD into clk, frames 16-bit
// slots on WS transitions and emits left/right pairs from the same frame.
module i2s_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  i2s_receiver_if.slave bus
);

  typedef enum logic {HUNT, RECEIVE} state_t;

  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, sd_sync;
  logic                   bclk_d;
  logic                   rise, ws_q, sd_q;

  state_t                 state, state_next;
  logic [DATA_WIDTH-1:0]  shift, word, left_hold;
  logic [DATA_WIDTH-1:0]  left_sample_q, right_sample_q;
  logic                   ws_prev, left_ok;
  logic [4:0]             bit_cnt;
  logic                   transition, word_done, word_good;
  logic                   sample_valid_q, frame_error_q;

  // Edge detect is registered together with WS/SD so all three stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      bclk_d    <= 1'b0;
      rise      <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what gives a real multi-flop chain.
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bus.bit_clock};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0],   bus.word_select};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0],   bus.sound_data};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      rise      <= bclk_sync[SYNC_STAGES-1] & ~bclk_d;
      ws_q      <= ws_sync[SYNC_STAGES-1];
      sd_q      <= sd_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value held and infer a latch.
    state_next = state;
    word_done  = 1'b0;
    word_good  = 1'b0;
    transition = (ws_q != ws_prev);
    word       = {shift[DATA_WIDTH-2:0], sd_q};
    if (rise) begin
      case (state)
        HUNT:    if (transition) state_next = RECEIVE;
        RECEIVE: if (transition) begin
          word_done = 1'b1;
          word_good = (bit_cnt == LAST_BIT);
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift          <= '0;
      ws_prev        <= 1'b0;
      bit_cnt        <= '0;
      left_hold      <= '0;
      left_ok        <= 1'b0;
      left_sample_q  <= '0;
      right_sample_q <= '0;
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
      if (rise) begin
        shift   <= word;
        ws_prev <= ws_q;
        if (transition)
          bit_cnt <= '0;
        else if (state == RECEIVE && bit_cnt != CNT_MAX)
          bit_cnt <= bit_cnt + 5'd1;

        // A right word is only paired with a left word from the same frame.
        if (word_done) begin
          if (!word_good) begin
            frame_error_q <= 1'b1;
            left_ok       <= 1'b0;
          end else if (!ws_prev) begin
            left_hold <= word;
            left_ok   <= 1'b1;
          end else begin
            if (left_ok) begin
              left_sample_q  <= left_hold;
              right_sample_q <= word;
              sample_valid_q <= 1'b1;
            end
            left_ok <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.left_sample         = left_sample_q;
  assign bus.right_sample        = right_sample_q;
  assign bus.sample_valid        = sample_valid_q;
  assign bus.frame_error         = frame_error_q;
  assign bus.testing_bit_counter = bit_cnt;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed and randomized I2S frames checked against a slot-level model of
// the receiver's pairing and framing rules.
module tb_i2s_receiver;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_receiver_if #(.DATA_WIDTH(DW)) bus();

  i2s_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        is_err;
    logic [15:0] l;
    logic [15:0] r;
  } event_t;

  event_t      exp_q[$];
  event_t      mon_ev;
  int          errors = 0;
  int          checks = 0;
  int          n_valid = 0;
  bit          m_hunting, m_left_ok;
  logic [15:0] m_left_hold;
  logic [15:0] exp_left, exp_right;
  longint      cyc = 0;
  longint      last_valid_cyc = -1;
  bit          spacing_on = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hunting   = 1;
    m_left_ok   = 0;
    m_left_hold = '0;
    exp_q.delete();
    exp_left    = '0;
    exp_right   = '0;
  endtask

  // Called once per slot, before its LSB (the WS-transition bit) is sent.
  task automatic model_slot(input logic ch, input int len, input logic [15:0] w);
    event_t ev;
    if (rst) return;
    if (m_hunting) begin
      m_hunting = 0;
    end else if (len != 16) begin
      ev.is_err = 1; ev.l = '0; ev.r = '0;
      exp_q.push_back(ev);
      m_left_ok = 0;
    end else if (ch == 1'b0) begin
      m_left_hold = w;
      m_left_ok   = 1;
    end else begin
      if (m_left_ok) begin
        ev.is_err = 0; ev.l = m_left_hold; ev.r = w;
        exp_q.push_back(ev);
      end
      m_left_ok = 0;
    end
  endtask

  // One BCLK period of 8 clk; optionally measure pair latency off this rise.
  task automatic send_bit(input logic ws, input logic sd, input bit measure);
    @(negedge clk);
    bus.word_select = ws;
    bus.sound_data  = sd;
    repeat (3) @(negedge clk);
    bus.bit_clock = 1'b1;
    if (measure) begin
      repeat (3) @(posedge clk);
      #1 check("latency_early", bus.sample_valid, 1'b0);
      @(posedge clk);
      #1 check("latency_exact", bus.sample_valid, 1'b1);
      @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
    bus.bit_clock = 1'b0;
  endtask

  task automatic send_slot(input logic ch, input logic [15:0] w, input int len, input bit measure);
    for (int i = 0; i < len - 1; i++) begin
      int idx = len - 1 - i;
      send_bit(ch, (idx < 16) ? w[idx] : 1'($urandom), 0);
    end
    model_slot(ch, len, w);
    send_bit(~ch, w[0], measure);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit measure);
    send_slot(1'b0, l, 16, 0);
    send_slot(1'b1, r, 16, measure);
  endtask

  task automatic settle_and_check(input string tag);
    repeat (12) @(negedge clk);
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
    check({tag, "_hold_left"}, bus.left_sample, exp_left);
    check({tag, "_hold_right"}, bus.right_sample, exp_right);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b0) begin
      if (bus.sample_valid === 1'b1) begin
        n_valid++;
        if (exp_q.size() == 0 || exp_q[0].is_err) begin
          check("valid_unexpected", bus.sample_valid, 1'b0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("pair_left", bus.left_sample, mon_ev.l);
          check("pair_right", bus.right_sample, mon_ev.r);
          exp_left  = mon_ev.l;
          exp_right = mon_ev.r;
          if (spacing_on && last_valid_cyc >= 0)
            check("valid_spacing", 32'(cyc - last_valid_cyc), 256);
        end
        last_valid_cyc = cyc;
      end
      if (bus.frame_error === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_err) begin
          check("error_unexpected", bus.frame_error, 1'b0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("error_vs_valid", bus.sample_valid, 1'b0);
        end
      end
    end
  end

  initial begin
    logic [15:0] rl, rr;
    int          ll, lr;
    bus.bit_clock   = 1'b0;
    bus.word_select = 1'b0;
    bus.sound_data  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset held while the link runs: nothing may come out.
    send_frame(16'h1234, 16'h5678, 0);
    check("rst_left", bus.left_sample, 0);
    check("rst_right", bus.right_sample, 0);
    check("rst_valid", bus.sample_valid, 0);
    check("rst_error", bus.frame_error, 0);
    check("rst_cnt", bus.testing_bit_counter, 0);

    // Release partway into a left slot; needs two transitions before a pair.
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'($urandom), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) send_bit(1'b0, 1'($urandom), 0);
    model_slot(1'b0, 16, 16'h0);
    send_bit(1'b1, 1'b0, 0);
    send_slot(1'b1, 16'hBEEF, 16, 0);
    repeat (8) @(negedge clk);
    check("no_pair_before_hunt_done", 32'(n_valid), 0);

    // Loopback stream with latency measurement and 256-cycle spacing.
    send_frame(16'hA5C3, 16'h3C5A, 0);
    spacing_on     = 1;
    last_valid_cyc = -1;
    send_frame(16'hA5C3, 16'h3C5A, 0);
    send_frame(16'hA5C3, 16'h3C5A, 1);
    send_frame(16'hA5C3, 16'h3C5A, 0);
    send_frame(16'hA5C3, 16'h3C5A, 0);
    spacing_on = 0;
    settle_and_check("loopback");

    // Boundary values: MSB-first order and LSB on the transition edge.
    send_frame(16'h0000, 16'hFFFF, 0);
    send_frame(16'h8000, 16'h0001, 0);
    settle_and_check("boundary");

    // Short left slot: one error, previous pair held, then recovery.
    send_slot(1'b0, 16'h1111, 15, 0);
    send_slot(1'b1, 16'h2222, 16, 0);
    settle_and_check("short_left");
    send_frame(16'h1357, 16'h2468, 0);
    // Long right slot.
    send_slot(1'b0, 16'h3333, 16, 0);
    send_slot(1'b1, 16'h4444, 20, 0);
    settle_and_check("long_right");
    send_frame(16'h9ABC, 16'hDEF0, 0);
    // 48-bit slot would look good if the counter wrapped.
    send_slot(1'b0, 16'h5555, 48, 0);
    send_slot(1'b1, 16'h6666, 16, 0);
    // WS toggling on consecutive rises.
    send_slot(1'b0, 16'h7777, 1, 0);
    send_slot(1'b1, 16'h8888, 16, 0);
    send_frame(16'hCAFE, 16'hF00D, 0);
    settle_and_check("edge_slots");

    // Randomized frames with occasional wrong-length slots.
    for (int f = 0; f < 20; f++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      ll = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 24)) : 16;
      lr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 24)) : 16;
      send_slot(1'b0, rl, ll, 0);
      send_slot(1'b1, rr, lr, 0);
    end
    send_frame(16'hC0DE, 16'hD00D, 0);
    settle_and_check("random");

    // Reset after 7 bits of a left word.
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'($urandom), 0);
    check("mid_cnt_before_rst", bus.testing_bit_counter, 7);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_left", bus.left_sample, 0);
    check("mid_rst_right", bus.right_sample, 0);
    check("mid_rst_cnt", bus.testing_bit_counter, 0);
    check("mid_rst_valid", bus.sample_valid, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'($urandom), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom), 0);
    model_slot(1'b0, 16, 16'h0);
    send_bit(1'b1, 1'b1, 0);
    send_slot(1'b1, 16'h0F0F, 16, 0);
    send_frame(16'h600D, 16'hF11E, 0);
    settle_and_check("mid_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
